// File: rtl/screen_mem_ctrl_pkg.sv
// screen_pkg: shared constants, FSM states and window decode for the screen memory controller
package screen_pkg;
  localparam logic [15:0] SCREEN_BASE = 16'h0200;
  localparam int SCREEN_WORDS = 1024;
  localparam int SCREEN_AW = 10;
  localparam int PIX_W = 8;
  typedef enum logic {IDLE, CLEAR} state_e;
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base, input int words);
    return (addr >= base) && (32'(addr - base) < words);
  endfunction
endpackage

// File: rtl/screen_mem_ctrl_fifo.sv
// sync_fifo: first-word fall-through FIFO; pushes while full are ignored
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic push, pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/screen_mem_ctrl.sv
// screen_mem_ctrl: 32x32 framebuffer with buffered CPU writes, a priority renderer read port
// and a hardware clear that only uses cycles the renderer leaves free.
module screen_mem_ctrl #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] SCREEN_BASE  = screen_pkg::SCREEN_BASE,
  parameter int          SCREEN_WORDS = screen_pkg::SCREEN_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_stall,
  input  logic        screen_read_en,
  input  logic [10:0] screen_read_addr,
  output logic [7:0]  screen_read_data,
  input  logic        clear_req,
  output logic        busy,
  output logic        overflow
);
  import screen_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = SCREEN_AW + PIX_W;
  localparam logic [SCREEN_AW-1:0] LAST = SCREEN_AW'(SCREEN_WORDS - 1);
  logic [PIX_W-1:0] mem [SCREEN_WORDS];
  state_e state_q, state_d;
  logic [SCREEN_AW-1:0] clr_q, clr_d, rd_idx, ram_idx;
  logic [PIX_W-1:0] rdata_q, ram_wdata;
  logic ovf_q;
  logic [EW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [15:0] rd_addr;
  logic fifo_full, fifo_empty, fifo_pop, enq, rd_hit, ram_we;
  assign rd_addr = {5'd0, screen_read_addr};
  assign rd_idx = SCREEN_AW'(rd_addr - SCREEN_BASE);
  assign rd_hit = screen_read_en && in_window(rd_addr, SCREEN_BASE, SCREEN_WORDS);
  assign enq = cpu_we && in_window(cpu_addr, SCREEN_BASE, SCREEN_WORDS);
  assign fifo_pop = !rd_hit && state_q == IDLE && !fifo_empty;
  // a restarting clear_req in CLEAR consumes the cycle without writing
  assign ram_we = !rd_hit && (state_q == CLEAR ? !clear_req : !fifo_empty);
  assign ram_idx = state_q == CLEAR ? clr_q : fifo_dout[EW-1:PIX_W];
  assign ram_wdata = state_q == CLEAR ? '0 : fifo_dout[PIX_W-1:0];
  assign cpu_stall = fifo_full;
  assign busy = state_q == CLEAR || fifo_count != '0;
  assign overflow = ovf_q;
  assign screen_read_data = rdata_q;
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (enq),
    .din   ({SCREEN_AW'(cpu_addr - SCREEN_BASE), cpu_dout}),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    if (clear_req) begin
      state_d = CLEAR;
      clr_d = '0;
    end else if (state_q == CLEAR && !rd_hit) begin
      state_d = clr_q == LAST ? IDLE : CLEAR;
      clr_d = clr_q == LAST ? clr_q : clr_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q <= '0;
      rdata_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      if (screen_read_en) rdata_q <= rd_hit ? mem[rd_idx] : '0;
      if (enq && fifo_full) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= ram_wdata;
  end
endmodule

// File: tb/tb_screen_mem_ctrl.sv
// tb_screen_mem_ctrl: directed and randomized checks against a queue/array model of the screen memory
module tb_screen_mem_ctrl;
  logic clk = 0, reset = 0, cpu_we = 0, screen_read_en = 0, clear_req = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0] cpu_dout = 0;
  logic [10:0] screen_read_addr = 0;
  logic cpu_stall, busy, overflow;
  logic [7:0] screen_read_data;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  screen_mem_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_stall(cpu_stall), .screen_read_en(screen_read_en), .screen_read_addr(screen_read_addr),
    .screen_read_data(screen_read_data), .clear_req(clear_req), .busy(busy), .overflow(overflow)
  );

  typedef struct {int idx; logic [7:0] d;} ent_t;
  logic [7:0] mm [1024];
  ent_t q[$];
  bit m_clr, m_ovf;
  int m_ptr;
  logic [7:0] m_rd;

  function automatic bit win(int a);
    return a >= 'h200 && a < 'h600;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_clr = 0;
    m_ovf = 0;
    m_rd = 8'h00;
  endtask

  task automatic model_step();
    bit hit = screen_read_en && win(int'(screen_read_addr));
    bit was_full = q.size() == 4;
    if (reset) begin
      model_reset();
      return;
    end
    if (screen_read_en) m_rd = hit ? mm[int'(screen_read_addr) - 'h200] : 8'h00;
    if (m_clr) begin
      if (clear_req) m_ptr = 0;
      else if (!hit) begin
        mm[m_ptr] = 8'h00;
        if (m_ptr == 1023) m_clr = 0; else m_ptr++;
      end
    end else begin
      if (!hit && q.size() > 0) begin
        ent_t e = q.pop_front();
        mm[e.idx] = e.d;
      end
      if (clear_req) begin
        m_clr = 1;
        m_ptr = 0;
      end
    end
    if (cpu_we && win(int'(cpu_addr))) begin
      if (was_full) m_ovf = 1;
      else q.push_back('{int'(cpu_addr) - 'h200, cpu_dout});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rdata", screen_read_data, m_rd);
    chk("busy", busy, m_clr || q.size() != 0);
    chk("stall", cpu_stall, q.size() == 4);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    cpu_we = 1; cpu_addr = 16'(a); cpu_dout = d;
    tick();
    cpu_we = 0;
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    screen_read_en = 1; screen_read_addr = 11'(a);
    tick();
    screen_read_en = 0;
    v = screen_read_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", busy, 0);
  endtask

  task automatic read_all(input string tag, input int special, input logic [7:0] sval);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      screen_read_en = 1; screen_read_addr = 11'('h200 + i);
      tick();
      if (screen_read_data !== ((i == special) ? sval : 8'h00)) bad++;
    end
    screen_read_en = 0;
    chk(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    #1 reset = 1;
    #2;
    model_reset();
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", screen_read_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    tick(); tick();
    #3 reset = 0;
    clear_req = 1; tick(); clear_req = 0;
    wait_idle();

    wr('h200, 8'h05);
    chk("t1_busy_high", busy, 1);
    tick();
    chk("t1_busy_low", busy, 0);
    rd('h200, v);
    chk("t1_read", v, 8'h05);

    screen_read_en = 1; screen_read_addr = 11'h300;
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1; cpu_addr = 16'('h200 + i); cpu_dout = 8'(8'h11 + i);
      tick();
      if (i == 3) chk("t2_stall", cpu_stall, 1);
      if (i == 4) chk("t2_overflow", overflow, 1);
    end
    cpu_we = 0; screen_read_en = 0;
    wait_idle();
    rd('h203, v); chk("t2_read_4th", v, 8'h14);
    rd('h204, v); chk("t2_dropped", v, 8'h00);

    wr('h100, 8'hAA); chk("t3_busy_lo", busy, 0);
    wr('h600, 8'hBB); chk("t3_busy_hi", busy, 0);
    rd('h100, v); chk("t3_read_out", v, 8'h00);

    for (int i = 0; i < 1024; i++) wr('h200 + i, 8'h07);
    wait_idle();
    rd('h3FF, v); chk("t4_filled", v, 8'h07);
    clear_req = 1; tick(); clear_req = 0;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("t4_clear_cycles", n, 1024);
    read_all("t4_all_zero", -1, 8'h00);

    for (int i = 0; i < 1024; i++) wr('h200 + i, 8'h07);
    wait_idle();
    clear_req = 1; tick(); clear_req = 0;
    repeat (10) tick();
    wr('h210, 8'h03);
    wait_idle();
    read_all("t5_after_clear", 'h10, 8'h03);

    for (int i = 0; i < 2000; i++) begin
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom_range('h1F0, 'h610));
      cpu_dout = 8'($urandom);
      screen_read_en = $urandom_range(0, 9) < 4;
      screen_read_addr = 11'($urandom_range('h1F0, 'h610));
      clear_req = $urandom_range(0, 499) == 0;
      tick();
    end
    cpu_we = 0; screen_read_en = 0; clear_req = 0;
    wait_idle();

    wr('h3F4, 8'h5A);
    wait_idle();
    rd('h3F4, v); chk("t6_pre", v, 8'h5A);
    clear_req = 1; tick(); clear_req = 0;
    repeat (298) tick();
    wr('h205, 8'h99);
    wr('h206, 8'h98);
    #2 reset = 1;
    #1;
    model_reset();
    chk("t6_rst_rdata", screen_read_data, 8'h00);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_stall", cpu_stall, 0);
    chk("t6_rst_overflow", overflow, 0);
    #3 reset = 0;
    tick();
    rd('h3F4, v); chk("t6_addr500", v, 8'h5A);
    rd('h200 + 299, v); chk("t6_cleared299", v, 8'h00);
    rd('h200 + 300, v);
    rd('h205, v);
    chk("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
